// File: rtl/ram_burst_ctrl.sv
// Burst initiator for the single-port RAM: turns one command into a run of
// stream handshakes, with the RAM write or read on the same edge as each handshake.
module ram_burst_ctrl #(
    parameter int AW = 6,
    parameter int DW = 16,
    parameter int LW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_in,
    output logic          ram_ld,
    input  logic [DW-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    localparam logic [LW-1:0] MaxLen = LW'(2 ** AW);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;

    logic wrPhase, rdPhase, wrFire, rdFire;

    // The latched direction also qualifies each phase, so the two stream sides can never be active together.
    assign wrPhase = (state_q == WRITE) && dir_q;
    assign rdPhase = (state_q == READ) && !dir_q;
    assign wrFire  = wrPhase && wr_valid;
    assign rdFire  = rdPhase && rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ptr_d = cmd_addr;
                    cnt_d = (cmd_len > MaxLen) ? MaxLen : cmd_len;
                    dir_d = cmd_wr;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = cmd_wr ? WRITE : READ;
                    end
                end
            end
            WRITE, READ: begin
                // The pointer wraps naturally at the top of the array.
                if (wrFire || rdFire) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign wr_ready  = wrPhase;
    assign rd_valid  = rdPhase;
    assign rd_data   = ram_out;
    assign ram_addr  = ptr_q;
    assign ram_in    = wr_data;
    // Gating with rst keeps the RAM safe while reset is asserted mid-cycle.
    assign ram_ld    = wrFire && !rst;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized self-checking bench for ram_burst_ctrl: a behavioural RAM plus a
// shadow copy of the expected contents predicts every stream and RAM access.
module tb_ram_burst_ctrl;

   localparam int AW    = 6;
   localparam int DW    = 16;
   localparam int LW    = 7;
   localparam int Depth = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_wr = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_in;
   logic          ram_ld;
   logic [DW-1:0] ram_out;

   logic [DW-1:0] mem    [Depth] = '{default: '0};
   logic [DW-1:0] shadow [Depth] = '{default: '0};
   int            ldEdges = 0;
   int            compareCount = 0;
   int            mismatchCount = 0;
   logic [DW-1:0] dataQueue [$];

   ram_burst_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_wr   (cmd_wr),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .busy     (busy),
      .done     (done),
      .ram_addr (ram_addr),
      .ram_in   (ram_in),
      .ram_ld   (ram_ld),
      .ram_out  (ram_out)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // The RAM the controller drives: combinational read, write on the rising edge when ld is high
   assign ram_out = mem[ram_addr];
   always @(posedge clk) begin
      if (ram_ld) begin
         mem[ram_addr] <= ram_in;
         ldEdges <= ldEdges + 1;
      end
   end

   // Compare one observed value with its expected value and count it
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at time %0t", tag, observed, expected, $time);
      end
   endtask

   // Run one complete burst: accept, per-word checks against the shadow, done pulse, return to idle.
   // stallMode < 0 stalls randomly, otherwise inserts exactly stallMode idle cycles before each word.
   task automatic applyStimulus(input bit isWrite, input int addr, input int len, input int stallMode);
      int eff;
      int wordsDone;
      int cycles;
      int budget;
      int stallLeft;
      int expAddr;
      int ldStart;
      bit hs;
      bit timedOut;
      eff       = (len > Depth) ? Depth : len;
      wordsDone = 0;
      cycles    = 0;
      budget    = 20 * eff + 50;
      stallLeft = (stallMode > 0) ? stallMode : 0;
      timedOut  = 1'b0;
      ldStart   = ldEdges;

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_wr    = isWrite;
      cmd_addr  = AW'(addr);
      cmd_len   = LW'(len);
      #1;
      checkOutput("cmdReady", cmd_ready, 1);
      checkOutput("idleBusy", busy, 0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_len   = LW'($urandom);

      while (wordsDone < eff && !timedOut) begin
         @(negedge clk);
         cycles++;
         if (stallMode < 0) begin
            hs = ($urandom_range(99) >= 30);
         end else if (stallLeft > 0) begin
            hs = 1'b0;
            stallLeft--;
         end else begin
            hs = 1'b1;
            stallLeft = stallMode;
         end
         expAddr = (addr + wordsDone) % Depth;
         if (isWrite) begin
            wr_valid = hs;
            wr_data  = (hs && dataQueue.size() > 0) ? dataQueue.pop_front() : DW'($urandom);
            rd_ready = 1'($urandom_range(1));
            #1;
            checkOutput("wrReady", wr_ready, 1);
            checkOutput("wrRdValid", rd_valid, 0);
            checkOutput("wrRamLd", ram_ld, hs);
            checkOutput("wrRamIn", ram_in, wr_data);
            if (hs) shadow[expAddr] = wr_data;
         end else begin
            rd_ready = hs;
            wr_valid = 1'($urandom_range(1));
            #1;
            checkOutput("rdValid", rd_valid, 1);
            checkOutput("rdWrReady", wr_ready, 0);
            checkOutput("rdRamLd", ram_ld, 0);
            checkOutput("rdData", rd_data, shadow[expAddr]);
         end
         checkOutput("ramAddr", ram_addr, expAddr);
         checkOutput("activeBusy", busy, 1);
         checkOutput("activeDone", done, 0);
         checkOutput("activeCmdReady", cmd_ready, 0);
         if (hs) wordsDone++;
         if (cycles >= budget) timedOut = 1'b1;
      end
      checkOutput("burstTimeout", timedOut, 0);

      @(negedge clk);
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      #1;
      checkOutput("donePulse", done, 1);
      checkOutput("doneBusy", busy, 1);
      checkOutput("doneCmdReady", cmd_ready, 0);
      checkOutput("doneRamLd", ram_ld, 0);

      @(negedge clk);
      #1;
      checkOutput("doneCleared", done, 0);
      checkOutput("backIdle", cmd_ready, 1);
      checkOutput("finalPtr", ram_addr, (addr + eff) % Depth);
      checkOutput("ldCount", ldEdges - ldStart, isWrite ? eff : 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ldStart;
      int a;
      int l;
      $display("[TB] starting ram_burst_ctrl bench");

      // Reset values while reset is held
      #12;
      checkOutput("rstCmdReady", cmd_ready, 1);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstRamLd", ram_ld, 0);
      checkOutput("rstRamAddr", ram_addr, 0);
      checkOutput("rstWrReady", wr_ready, 0);
      checkOutput("rstRdValid", rd_valid, 0);
      @(negedge clk);
      rst = 1'b0;

      // Basic write and read-back at address 5
      dataQueue = '{16'h1111, 16'h2222, 16'h3333};
      applyStimulus(1'b1, 5, 3, 0);
      applyStimulus(1'b0, 5, 3, 0);

      // Address wrap across the top of the array
      dataQueue = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
      applyStimulus(1'b1, 62, 4, 0);
      checkOutput("wrap62", mem[62], 16'h00A0);
      checkOutput("wrap1", mem[1], 16'h00A3);
      applyStimulus(1'b0, 62, 4, 0);

      // Read backpressure: three stall cycles before each word
      applyStimulus(1'b0, 0, 2, 3);

      // Zero-length bursts in both directions, then length saturation
      applyStimulus(1'b1, 17, 0, 0);
      applyStimulus(1'b0, 40, 0, 0);
      applyStimulus(1'b1, 9, 100, -1);
      applyStimulus(1'b0, 9, 64, -1);

      // Random bursts of mixed direction, length and stall pattern
      for (int i = 0; i < 30; i++) begin
         a = $urandom_range(Depth - 1);
         l = ($urandom_range(4) == 0) ? $urandom_range(127) : $urandom_range(8);
         applyStimulus(1'($urandom_range(1)), a, l, ($urandom_range(1) == 0) ? -1 : 0);
      end

      // Asynchronous reset after the second of four write handshakes
      ldStart = ldEdges;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_wr    = 1'b1;
      cmd_addr  = AW'(20);
      cmd_len   = LW'(4);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         wr_valid = 1'b1;
         wr_data  = DW'($urandom);
         shadow[20 + k] = wr_data;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midRstRamLd", ram_ld, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstDone", done, 0);
      checkOutput("midRstCmdReady", cmd_ready, 1);
      checkOutput("midRstWrReady", wr_ready, 0);
      checkOutput("midRstRamAddr", ram_addr, 0);
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("postRstDone", done, 0);
      checkOutput("postRstLdCount", ldEdges - ldStart, 2);
      applyStimulus(1'b0, 20, 4, -1);

      // Whole-array comparison of the RAM against the expected contents
      for (int i = 0; i < Depth; i++) begin
         checkOutput($sformatf("mem[%0d]", i), mem[i], shadow[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Initiator for the 64-word, 16-bit RAM array. It accepts a burst command (direction, start address, length) and drives the RAM's addr/in/ld port. Write bursts take data from a valid/ready input stream; read bursts return data on a valid/ready output stream. It sits between a stream producer/consumer (loader, CPU-side DMA) and the RAM.

Parameters:
AW, 6, address width; RAM depth is 2**AW words
DW, 16, data word width
LW, 7, command length width; maximum burst is 2**AW words

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  burst command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_wr  input  1  1 = write burst, 0 = read burst
cmd_addr  input  AW  start word address
cmd_len  input  LW  number of words, 0..127
wr_data  input  DW  write stream data
wr_valid  input  1  write stream word present
wr_ready  output  1  controller consumes a write word
rd_data  output  DW  read stream data
rd_valid  output  1  read stream word present
rd_ready  input  1  consumer accepts a read word
busy  output  1  high in WRITE, READ and DONE
done  output  1  one-cycle pulse at burst completion
ram_addr  output  AW  to RAM addr
ram_in  output  DW  to RAM in
ram_ld  output  1  to RAM ld; the RAM writes ram_in at the rising clk edge when ld=1
ram_out  input  DW  from RAM out; combinational read of ram_addr

Behaviour:
- Reset (asynchronous): state=IDLE; ptr=0; cnt=0; dir=0. Outputs: ram_ld=0, ram_addr=0, wr_ready=0, rd_valid=0, busy=0, done=0, cmd_ready=1. rst high forces ram_ld=0 combinationally, so no write occurs while in reset.
- States: IDLE, WRITE, READ, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: ptr<=cmd_addr; cnt<=min(cmd_len,64); dir<=cmd_wr.
  - If cmd_len==0, next state is DONE.
  - Otherwise next state is WRITE when cmd_wr=1, else READ.
- ram_addr=ptr in all states; ram_in=wr_data.
- WRITE: wr_ready=1; ram_ld=wr_valid. The RAM write happens at the same edge as the stream handshake, so there is zero added latency.
  - On each handshake: ptr<=ptr+1 (mod 64); cnt<=cnt-1.
  - When the handshake occurs with cnt==1, next state is DONE.
  - wr_valid=0 produces a stall: ram_ld=0 and state is held.
- READ: rd_valid=1; rd_data=ram_out (combinational, same cycle as ram_addr).
  - On rd_valid&rd_ready: ptr++ (mod 64); cnt--.
  - When the handshake occurs with cnt==1, next state is DONE.
  - rd_ready=0 produces a stall: ptr is held, so rd_data stays stable.
- Outside an active handshake: ram_ld=0, wr_ready=0 outside WRITE, rd_valid=0 outside READ.
- DONE: done=1 for exactly one cycle; cmd_ready=0; next state is IDLE. The earliest next command is accepted one cycle after the done pulse.
- Address wrap: ptr rolls from 63 to 0 inside a burst. A 64-word burst touches every word exactly once.
- Length saturation: cmd_len values 65..127 are treated as 64.
- A command presented while not in IDLE is ignored (cmd_ready=0) and must be held by the sender.
- Streams: wr_valid in READ/IDLE/DONE is ignored; rd_ready outside READ is ignored.
- Throughput: one word per cycle with no stalls. A burst of N≥1 occupies N cycles of WRITE/READ plus 1 cycle of DONE after the accept edge.
- Reset mid-burst: immediate return to IDLE with ptr=0. Words already written stay in RAM. No done pulse is produced.

Test Plan:
- Reset, then write cmd (addr=5, len=3) with data 0x1111, 0x2222, 0x3333 and wr_valid held high -> ram_ld high 3 cycles at ram_addr 5, 6, 7; then done pulse 1 cycle; then cmd_ready=1.
- Read cmd (addr=5, len=3) with rd_ready=1 -> rd_data 0x1111, 0x2222, 0x3333 on 3 consecutive cycles; then done.
- Wrap: write addr=62, len=4 with data 0xA0..0xA3 -> written to addresses 62, 63, 0, 1; a read-back burst from 62 returns the same values.
- Backpressure: read addr=0, len=2 with rd_ready low 3 cycles before each word -> rd_data held constant while stalled; exactly 2 handshakes; ram_ld never asserted.
- Edge lengths: cmd_len=0 -> DONE next cycle with no RAM access; cmd_len=100 -> exactly 64 writes, final ptr equals the start address.
- Async reset after the 2nd of 4 write handshakes -> outputs go to reset values immediately; only 2 words modified; no done pulse; a new command is accepted after reset is released.
